ir_cmd_ctrl: RTL and testbench
==============================

IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 SHALL have parameter MODE_COUNT, default 14: number of display modes; mode wraps over 0..MODE_COUNT-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 3: repeat frames ignored before auto-step starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 2: one auto-step per REPEAT_RATE repeat frames once stepping.
REQ-004 SHALL have parameter HOLD_TIMEOUT, default 6000000: clk cycles (120 ms at 50 MHz) without a repeat frame before the held key is released.
REQ-005 SHALL have ports: clk in 1, sole clock, rising edge; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: frameValid in 1, one-cycle pulse for a complete 32-bit frame; frameData in 32, frame bits, command byte [15:8], complement [7:0].
REQ-007 SHALL have port: repeatValid in 1, one-cycle pulse for a repeat frame.
REQ-008 SHALL have ports: mode out 4; showName out 1; cpuClkMode out 2; held out 1, high while a key is latched; cmdErr out 1, one-cycle pulse on a rejected frame; lastCmd out 8, last accepted command byte.

Function
REQ-009 SHALL implement FSM states IDLE and HELD; held = (state == HELD).
REQ-010 SHALL, on frameValid in either state, decode frameData[15:8] in the same cycle; outputs update on the next rising edge (latency 1).
REQ-011 SHALL act on accepted commands: 8'h62 toggles showName; 8'hE2 increments mode (MODE_COUNT-1 wraps to 0); 8'hA2 decrements mode (0 wraps to MODE_COUNT-1); 8'hC2 inverts both cpuClkMode bits.
REQ-012 SHALL, on an accepted frame, latch lastCmd, clear repCnt and rateCnt, restart the hold timer, and enter HELD.
REQ-013 SHALL, on a frame with an unknown command byte, leave all outputs except lastCmd unchanged, latch lastCmd, and enter HELD; no repeat action follows.
REQ-014 SHALL ignore repeatValid in IDLE.
REQ-015 SHALL, on repeatValid in HELD, restart the hold timer and saturating-increment repCnt (4 bits).
REQ-016 SHALL auto-step only for 8'hE2 and 8'hA2, only when repCnt >= REPEAT_DELAY.
  - Auto-step applies on the 1st qualifying repeat, then every REPEAT_RATE repeats, counted by rateCnt.
  - 8'h62, 8'hC2 and unknown codes SHALL never repeat.
REQ-017 SHALL return to IDLE when the hold timer reaches HOLD_TIMEOUT in HELD; mode, showName and cpuClkMode are unchanged on that return.
REQ-018 SHALL give frameValid priority when frameValid and repeatValid are both high in one cycle; repeatValid is dropped.
REQ-019 SHALL never stop the hold timer; it SHALL saturate at HOLD_TIMEOUT.

Reset
REQ-020 SHALL, on rst, set state IDLE, mode 0, showName 0, cpuClkMode 0, lastCmd 0, cmdErr 0, repCnt 0, rateCnt 0, timer 0.
REQ-021 SHALL give rst priority over all inputs, including an rst asserted in the same cycle as frameValid.

Configuration
REQ-022 SHALL, with IR_CHECKSUM_EN defined, reject frames where frameData[7:0] != ~frameData[15:8].
  - A rejected frame SHALL pulse cmdErr for 1 cycle, go to IDLE, and change no other output.
REQ-023 SHALL, without IR_CHECKSUM_EN, ignore frameData[7:0] and hold cmdErr at 0.

Structure
REQ-024 SHALL take the scan-code constants (CHANNEL_MINUS, CHANNEL, CHANNEL_PLUS, PLAY) and the FSM state encoding from the shared package ir_pkg.
REQ-025 SHALL implement the hold timer as sub-module ir_hold_timer (inputs restart, enable; output expired).

Verification
REQ-026 Frame 0x00FF_E21D after reset -> mode 1 and held 1 in the next cycle.
REQ-027 Frame 0x00FF_A25D at mode 0 -> mode 13 (wrap); then 0x00FF_E21D -> mode 0.
REQ-028 Frame 0xE2, then 8 repeats 10 ms apart (REPEAT_DELAY 3, REPEAT_RATE 2):
  - mode 0 -> 1 on the frame;
  - auto-steps on repeats 3, 5 and 7;
  - final mode 4.
REQ-029 Frame 0xC2, then 5 repeats -> cpuClkMode 3 only once; no timeout repeat occurs; after 120 ms of silence, held drops to 0.
REQ-030 With IR_CHECKSUM_EN, frame 0x00FF_6200 -> cmdErr pulses 1 cycle, showName unchanged; without the macro -> showName toggles.
REQ-031 Simultaneous frameValid(0x62) and repeatValid, then rst during HELD -> showName toggles once, then all outputs 0 and state IDLE.

Source files
------------

// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR remote command controller: the remote's scan
// codes for the four keys we act on, the controller FSM state encoding, and a
// helper that steps the display mode with wrap-around.
// ---------------------------------------------------------------------------
package ir_pkg;

  localparam logic [7:0] CHANNEL_MINUS = 8'hA2;
  localparam logic [7:0] CHANNEL       = 8'h62;
  localparam logic [7:0] CHANNEL_PLUS  = 8'hE2;
  localparam logic [7:0] PLAY          = 8'hC2;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  // Step a mode index up or down, wrapping over 0..modeCount-1.
  function automatic logic [3:0] nextMode(input logic [3:0] cur, input logic up,
                                          input int modeCount);
    int curI;
    int res;
    curI = int'(cur);
    if (up) res = (curI >= modeCount - 1) ? 0 : curI + 1;
    else    res = (curI == 0) ? modeCount - 1 : curI - 1;
    return 4'(res);
  endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// ---------------------------------------------------------------------------
// ir_hold_timer
// Counts clock cycles since the last restart and saturates at TIMEOUT.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (count cleared)
//   restart : clears the count this edge
//   enable  : allows counting when high
//   expired : high while the count equals TIMEOUT
// ---------------------------------------------------------------------------
module ir_hold_timer #(
  parameter int TIMEOUT = 6000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT));

  // Saturate instead of wrapping so a long silence never looks like a fresh key.
  always_comb begin
    cnt_d = cnt_q;
    if (restart)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ir_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ir_cmd_ctrl
// Turns decoded IR remote frames into display-control state. A full frame
// carries a command byte; repeat frames extend a held key and, for the
// channel up/down keys, auto-step the mode after an initial delay.
//
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   frameValid/frameData: one-cycle pulse with a 32-bit frame; command in
//                         [15:8], its complement in [7:0]
//   repeatValid         : one-cycle pulse for a repeat frame
//   mode                : display mode, wraps over 0..MODE_COUNT-1
//   showName            : toggled by CHANNEL
//   cpuClkMode          : both bits inverted by PLAY
//   held                : a key is latched (FSM in HELD)
//   cmdErr              : one-cycle pulse on a frame failing its checksum
//   lastCmd             : last accepted command byte
//
// Build option: define IR_CHECKSUM_EN to reject frames whose low byte is not
// the complement of the command byte. Without it the low byte is ignored and
// cmdErr stays 0.
// ---------------------------------------------------------------------------
module ir_cmd_ctrl
  import ir_pkg::*;
#(
  parameter int MODE_COUNT   = 14,
  parameter int REPEAT_DELAY = 3,
  parameter int REPEAT_RATE  = 2,
  parameter int HOLD_TIMEOUT = 6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameValid,
  input  logic [31:0] frameData,
  input  logic        repeatValid,
  output logic [3:0]  mode,
  output logic        showName,
  output logic [1:0]  cpuClkMode,
  output logic        held,
  output logic        cmdErr,
  output logic [7:0]  lastCmd
);

  state_e      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic        showName_q, showName_d;
  logic [1:0]  cpuClkMode_q, cpuClkMode_d;
  logic [7:0]  lastCmd_q, lastCmd_d;
  logic        cmdErr_q, cmdErr_d;
  logic [3:0]  repCnt_q, repCnt_d;
  logic [3:0]  rateCnt_q, rateCnt_d;

  logic        timerRestart;
  logic        timerExpired;
  logic [7:0]  cmdByte;
  logic        frameOk;
  logic [3:0]  repCntInc;
  logic        stepKey;
  logic        unusedBits;

  assign cmdByte    = frameData[15:8];
  assign unusedBits = ^{frameData[31:16], frameData[7:0]};

`ifdef IR_CHECKSUM_EN
  assign frameOk = (frameData[7:0] == ~cmdByte);
`else
  assign frameOk = 1'b1;
`endif

  assign repCntInc = (repCnt_q == 4'hF) ? repCnt_q : repCnt_q + 4'd1;
  assign stepKey   = (lastCmd_q == CHANNEL_PLUS) || (lastCmd_q == CHANNEL_MINUS);

  // The timer free-runs in both states; only restarts and saturation shape it.
  ir_hold_timer #(
    .TIMEOUT (HOLD_TIMEOUT)
  ) uHoldTimer (
    .clk     (clk),
    .rst     (rst),
    .restart (timerRestart),
    .enable  (1'b1),
    .expired (timerExpired)
  );

  // Next-state logic. A frame wins over a repeat in the same cycle; a repeat
  // arriving in the cycle the timer expires keeps the key held.
  // rateCnt counts qualifying repeats modulo REPEAT_RATE so the first
  // qualifying repeat steps and then every REPEAT_RATE-th one after it.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    showName_d   = showName_q;
    cpuClkMode_d = cpuClkMode_q;
    lastCmd_d    = lastCmd_q;
    cmdErr_d     = 1'b0;
    repCnt_d     = repCnt_q;
    rateCnt_d    = rateCnt_q;
    timerRestart = 1'b0;

    if (frameValid) begin
      if (!frameOk) begin
        cmdErr_d = 1'b1;
        state_d  = IDLE;
      end else begin
        lastCmd_d    = cmdByte;
        repCnt_d     = 4'd0;
        rateCnt_d    = 4'd0;
        timerRestart = 1'b1;
        state_d      = HELD;
        case (cmdByte)
          CHANNEL:       showName_d   = ~showName_q;
          CHANNEL_PLUS:  mode_d       = nextMode(mode_q, 1'b1, MODE_COUNT);
          CHANNEL_MINUS: mode_d       = nextMode(mode_q, 1'b0, MODE_COUNT);
          PLAY:          cpuClkMode_d = ~cpuClkMode_q;
          default:       ;
        endcase
      end
    end else if (repeatValid && (state_q == HELD)) begin
      timerRestart = 1'b1;
      repCnt_d     = repCntInc;
      if (stepKey && (int'(repCntInc) >= REPEAT_DELAY)) begin
        if (rateCnt_q == 4'd0)
          mode_d = nextMode(mode_q, lastCmd_q == CHANNEL_PLUS, MODE_COUNT);
        rateCnt_d = (int'(rateCnt_q) + 1 >= REPEAT_RATE) ? 4'd0 : rateCnt_q + 4'd1;
      end
    end else if ((state_q == HELD) && timerExpired) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 4'd0;
      showName_q   <= 1'b0;
      cpuClkMode_q <= 2'd0;
      lastCmd_q    <= 8'd0;
      cmdErr_q     <= 1'b0;
      repCnt_q     <= 4'd0;
      rateCnt_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      showName_q   <= showName_d;
      cpuClkMode_q <= cpuClkMode_d;
      lastCmd_q    <= lastCmd_d;
      cmdErr_q     <= cmdErr_d;
      repCnt_q     <= repCnt_d;
      rateCnt_q    <= rateCnt_d;
    end
  end

  assign mode       = mode_q;
  assign showName   = showName_q;
  assign cpuClkMode = cpuClkMode_q;
  assign held       = (state_q == HELD);
  assign cmdErr     = cmdErr_q;
  assign lastCmd    = lastCmd_q;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_cmd_ctrl
// Self-checking bench for ir_cmd_ctrl with a shortened hold timeout.
// ---------------------------------------------------------------------------
module tb_ir_cmd_ctrl;

  localparam int MC = 14;
  localparam int RD = 3;
  localparam int RR = 2;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frameValid = 1'b0;
  logic [31:0] frameData = '0;
  logic        repeatValid = 1'b0;
  logic [3:0]  mode;
  logic        showName;
  logic [1:0]  cpuClkMode;
  logic        held;
  logic        cmdErr;
  logic [7:0]  lastCmd;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain counts of repeats and silent cycles.
  int         mMode, mReps, mSilent;
  logic       mShow, mHeld, mErr;
  logic [1:0] mCpu;
  logic [7:0] mLast;

  typedef struct {
    logic        r;
    logic        f;
    logic        rv;
    logic [31:0] d;
    logic [3:0]  eMode;
    logic        eShow;
    logic [1:0]  eCpu;
    logic        eHeld;
    logic [7:0]  eLast;
  } vec_t;

  vec_t table_[14];

  ir_cmd_ctrl #(
    .MODE_COUNT   (MC),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .HOLD_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frameValid  (frameValid),
    .frameData   (frameData),
    .repeatValid (repeatValid),
    .mode        (mode),
    .showName    (showName),
    .cpuClkMode  (cpuClkMode),
    .held        (held),
    .cmdErr      (cmdErr),
    .lastCmd     (lastCmd)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] dutBundle();
    return {mode, showName, cpuClkMode, held, cmdErr, lastCmd};
  endfunction

  task automatic modelUpdate(input logic r, input logic f, input logic [31:0] d,
                             input logic rvIn);
    logic [7:0] cmd;
    logic       ok;
    if (r) begin
      mMode = 0; mShow = 0; mCpu = 0; mLast = 0; mErr = 0;
      mHeld = 0; mReps = 0; mSilent = 0;
    end else begin
      mErr = 0;
      if (f) begin
        cmd = d[15:8];
`ifdef IR_CHECKSUM_EN
        ok = (d[7:0] == ~cmd);
`else
        ok = 1'b1;
`endif
        if (!ok) begin
          mErr = 1; mHeld = 0; mSilent++;
        end else begin
          mLast = cmd; mHeld = 1; mReps = 0; mSilent = 0;
          case (cmd)
            8'h62: mShow = ~mShow;
            8'hE2: mMode = (mMode + 1) % MC;
            8'hA2: mMode = (mMode + MC - 1) % MC;
            8'hC2: mCpu = ~mCpu;
            default: ;
          endcase
        end
      end else if (rvIn && mHeld) begin
        mSilent = 0;
        mReps++;
        if ((mLast == 8'hE2 || mLast == 8'hA2) && mReps >= RD && ((mReps - RD) % RR) == 0)
          mMode = (mLast == 8'hE2) ? (mMode + 1) % MC : (mMode + MC - 1) % MC;
      end else begin
        if (mHeld && mSilent >= TO) mHeld = 0;
        mSilent++;
      end
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input logic r, input logic f, input logic [31:0] d,
                               input logic rvIn);
    rst = r; frameValid = f; frameData = d; repeatValid = rvIn;
    @(posedge clk);
    #1;
    modelUpdate(r, f, d, rvIn);
    rst = 0; frameValid = 0; repeatValid = 0;
  endtask

  task automatic checkOutput(input string name, input logic [16:0] got,
                             input logic [16:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, dutBundle(), {4'(mMode), mShow, mCpu, mHeld, mErr, mLast});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0);
  endtask

  initial begin
    int expSteps[8];
    int waitCnt;
    logic dropped;

    //                r  f  rv  data          mode sn cpu held last
    table_[0]  = '{1, 0, 0, 32'h0,         4'd0,  0, 2'd0, 0, 8'h00};
    table_[1]  = '{0, 1, 0, 32'h00FFE21D,  4'd1,  0, 2'd0, 1, 8'hE2};
    table_[2]  = '{0, 1, 0, 32'h00FFA25D,  4'd0,  0, 2'd0, 1, 8'hA2};
    table_[3]  = '{0, 1, 0, 32'h00FFA25D,  4'd13, 0, 2'd0, 1, 8'hA2};
    table_[4]  = '{0, 1, 0, 32'h00FFE21D,  4'd0,  0, 2'd0, 1, 8'hE2};
    table_[5]  = '{0, 1, 0, 32'h00FF629D,  4'd0,  1, 2'd0, 1, 8'h62};
    table_[6]  = '{0, 1, 0, 32'h00FFC23D,  4'd0,  1, 2'd3, 1, 8'hC2};
    table_[7]  = '{0, 1, 0, 32'h00FF12ED,  4'd0,  1, 2'd3, 1, 8'h12};
    table_[8]  = '{0, 0, 1, 32'h0,         4'd0,  1, 2'd3, 1, 8'h12};
    table_[9]  = '{0, 1, 1, 32'h00FF629D,  4'd0,  0, 2'd3, 1, 8'h62};
    table_[10] = '{1, 1, 0, 32'h00FFE21D,  4'd0,  0, 2'd0, 0, 8'h00};
    table_[11] = '{0, 0, 1, 32'h0,         4'd0,  0, 2'd0, 0, 8'h00};
    table_[12] = '{0, 1, 0, 32'h00FFC23D,  4'd0,  0, 2'd3, 1, 8'hC2};
    table_[13] = '{0, 1, 0, 32'h1234E21D,  4'd1,  0, 2'd3, 1, 8'hE2};

    expSteps = '{1, 1, 2, 2, 3, 3, 4, 4};

    applyStimulus(1, 0, 32'h0, 0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(table_[i].r, table_[i].f, table_[i].d, table_[i].rv);
      checkOutput($sformatf("table[%0d]", i), dutBundle(),
                  {table_[i].eMode, table_[i].eShow, table_[i].eCpu,
                   table_[i].eHeld, 1'b0, table_[i].eLast});
    end

    // Held CHANNEL_PLUS: steps on repeats 3, 5, 7.
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00FFE21D, 0);
    checkOutput("autostep frame", 17'(mode), 17'd1);
    for (int k = 0; k < 8; k++) begin
      idle(4);
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput($sformatf("autostep rep%0d", k + 1), 17'(mode), 17'(expSteps[k]));
    end
    checkOutput("autostep held", 17'(held), 17'd1);

    // Held PLAY never repeats; silence then releases the key.
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00FFC23D, 0);
    for (int k = 0; k < 5; k++) begin
      idle(4);
      applyStimulus(0, 0, 32'h0, 1);
      checkOutput($sformatf("play rep%0d", k + 1), 17'(cpuClkMode), 17'd3);
    end
    idle(TO - 1);
    checkOutput("hold before timeout", 17'(held), 17'd1);
    dropped = 0;
    waitCnt = 0;
    while (!dropped && waitCnt < 10) begin
      applyStimulus(0, 0, 32'h0, 0);
      waitCnt++;
      if (!held) dropped = 1;
    end
    checkOutput("hold released", 17'(dropped), 17'd1);
    checkOutput("timeout keeps cpu", 17'(cpuClkMode), 17'd3);

    // Frame with a bad complement byte.
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h00FF6200, 0);
`ifdef IR_CHECKSUM_EN
    checkOutput("bad chk pulse", {15'd0, cmdErr, showName}, 17'b10);
    checkOutput("bad chk held", 17'(held), 17'd0);
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("bad chk pulse end", 17'(cmdErr), 17'd0);
`else
    checkOutput("no chk toggle", {15'd0, cmdErr, showName}, 17'b01);
    checkOutput("no chk held", 17'(held), 17'd1);
`endif

    // Randomized bursts against the model.
    for (int b = 0; b < 80; b++) begin
      logic       active;
      logic [7:0] code;
      logic [7:0] lo;
      int         gap;
      int         sel;
      active = 1'($urandom_range(0, 1));
      gap    = int'($urandom_range(1, 70));
      sel    = int'($urandom_range(0, 5));
      case (sel)
        0: code = 8'hE2;
        1: code = 8'hA2;
        2: code = 8'h62;
        3: code = 8'hC2;
        4: code = 8'($urandom);
        default: code = 8'hE2;
      endcase
      lo = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ~code;
      applyStimulus($urandom_range(0, 39) == 0, 1, {16'($urandom), code, lo},
                    $urandom_range(0, 3) == 0);
      checkModel($sformatf("rand b%0d frame", b));
      for (int g = 0; g < gap; g++) begin
        applyStimulus(0, 0, $urandom, active && ($urandom_range(0, 3) == 0));
        checkModel($sformatf("rand b%0d c%0d", b, g));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
